// File: rtl/tusca_recepcao_config_pkg.sv
// -----------------------------------------------------------------------------
// tusca_recepcao_config_pkg
//   Constants and helpers that describe the TUSCA configuration frame. The PC
//   side tooling builds frames from the same values, so they live here.
//   Frame: CAB_CONFIG, INT_H, INT_L, LIMIAR, CHK
//   CHK  : CAB_CONFIG ^ INT_H ^ INT_L ^ LIMIAR (8-bit XOR)
// -----------------------------------------------------------------------------
package tusca_recepcao_config_pkg;

    // State codes, also exported on db_estado.
    localparam logic [3:0] ST_OCIOSO     = 4'd0;
    localparam logic [3:0] ST_ESP_CAB    = 4'd1;
    localparam logic [3:0] ST_ESP_INT_H  = 4'd2;
    localparam logic [3:0] ST_ESP_INT_L  = 4'd3;
    localparam logic [3:0] ST_ESP_LIMIAR = 4'd4;
    localparam logic [3:0] ST_ESP_CHK    = 4'd5;
    localparam logic [3:0] ST_VALIDA     = 4'd6;
    localparam logic [3:0] ST_ATUALIZA   = 4'd7;
    localparam logic [3:0] ST_ERRO       = 4'd8;

    typedef enum logic [3:0] {
        OCIOSO     = ST_OCIOSO,
        ESP_CAB    = ST_ESP_CAB,
        ESP_INT_H  = ST_ESP_INT_H,
        ESP_INT_L  = ST_ESP_INT_L,
        ESP_LIMIAR = ST_ESP_LIMIAR,
        ESP_CHK    = ST_ESP_CHK,
        VALIDA     = ST_VALIDA,
        ATUALIZA   = ST_ATUALIZA,
        ERRO       = ST_ERRO
    } estado_t;

    localparam logic [7:0] CAB_CONFIG = 8'h43;
    localparam int         TAM_QUADRO = 5;

    // One collection state per frame byte, starting at the header state.
    localparam logic [3:0] ST_ULTIMO_BYTE = 4'(ST_ESP_CAB + TAM_QUADRO - 1);

    function automatic logic [7:0] calc_chk(input logic [7:0] int_h,
                                            input logic [7:0] int_l,
                                            input logic [7:0] limiar);
        return CAB_CONFIG ^ int_h ^ int_l ^ limiar;
    endfunction

    // True while the FSM is collecting frame bytes.
    function automatic logic em_coleta(input estado_t e);
        return (e >= ST_ESP_CAB) && (e <= ST_ULTIMO_BYTE);
    endfunction

endpackage

// File: rtl/tusca_contador_timeout.sv
// -----------------------------------------------------------------------------
// tusca_contador_timeout
//   Inter-byte timeout counter. Saturates at LIMITE-1 instead of wrapping so
//   a stuck terminal count cannot silently roll back to zero.
// Ports
//   clock      in  1  system clock
//   reset_n    in  1  asynchronous active-low reset
//   limpar     in  1  synchronous clear (priority over habilitar)
//   habilitar  in  1  count enable
//   fim        out 1  count has reached LIMITE-1
// -----------------------------------------------------------------------------
module tusca_contador_timeout #(
    parameter int LIMITE = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic limpar,
    input  logic habilitar,
    output logic fim
);

    localparam int             W        = (LIMITE > 1) ? $clog2(LIMITE) : 1;
    localparam logic [W-1:0]   TERMINAL = W'(LIMITE - 1);

    logic [W-1:0] contagem;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contagem <= '0;
        end else if (limpar) begin
            contagem <= '0;
        end else if (habilitar && (contagem != TERMINAL)) begin
            contagem <= contagem + W'(1);
        end
    end

    assign fim = (contagem == TERMINAL);

endmodule

// File: rtl/tusca_recepcao_config.sv
// -----------------------------------------------------------------------------
// tusca_recepcao_config
//   Responder for the receber_config / pronto_config handshake. On a start
//   pulse it collects one configuration frame from the UART byte stream,
//   validates it and commits interval and threshold. Every started transaction
//   ends with exactly one pronto_config pulse (with erro_config on failure),
//   unless it is cancelled.
// Ports
//   clock           in  1   system clock, rising edge
//   reset_n         in  1   asynchronous active-low reset
//   receber_config  in  1   start request (honoured only when idle)
//   cancelar        in  1   abort collection / validation
//   dado_rx         in  8   received byte, valid with pronto_rx
//   pronto_rx       in  1   byte strobe
//   pronto_config   out 1   transaction finished
//   erro_config     out 1   transaction failed (with pronto_config)
//   intervalo       out 16  committed measurement interval
//   limiar_temp     out 8   committed temperature threshold
//   recebendo       out 1   frame collection in progress
//   db_estado       out 4   current state code
// -----------------------------------------------------------------------------
module tusca_recepcao_config
    import tusca_recepcao_config_pkg::*;
#(
    parameter int          TIMEOUT_CICLOS  = 50_000_000,
    parameter logic [15:0] INTERVALO_RESET = 16'd2000,
    parameter logic [7:0]  LIMIAR_RESET    = 8'd30
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        receber_config,
    input  logic        cancelar,
    input  logic [7:0]  dado_rx,
    input  logic        pronto_rx,
    output logic        pronto_config,
    output logic        erro_config,
    output logic [15:0] intervalo,
    output logic [7:0]  limiar_temp,
    output logic        recebendo,
    output logic [3:0]  db_estado
);

    estado_t    estado, estado_prox;
    logic [7:0] sh_int_h, sh_int_l, sh_limiar, sh_chk;
    logic       coletando;
    logic       byte_aceito;
    logic       fim_timeout;
    logic       limpa_timeout;
    logic       quadro_ok;

    assign coletando   = em_coleta(estado);
    // Cancel wins over a simultaneous byte.
    assign byte_aceito = coletando && pronto_rx && !cancelar;
    assign quadro_ok   = (calc_chk(sh_int_h, sh_int_l, sh_limiar) == sh_chk) &&
                         ({sh_int_h, sh_int_l} != 16'h0000);

    // Any strobe in a collection state restarts the window, including a
    // discarded non-header byte while resynchronising.
    assign limpa_timeout = ((estado == OCIOSO) && receber_config) ||
                           (coletando && pronto_rx);

    tusca_contador_timeout #(
        .LIMITE (TIMEOUT_CICLOS)
    ) u_timeout (
        .clock     (clock),
        .reset_n   (reset_n),
        .limpar    (limpa_timeout),
        .habilitar (coletando),
        .fim       (fim_timeout)
    );

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO: begin
                if (receber_config) estado_prox = ESP_CAB;
            end
            ESP_CAB, ESP_INT_H, ESP_INT_L, ESP_LIMIAR, ESP_CHK: begin
                if (cancelar) begin
                    estado_prox = OCIOSO;
                end else if (pronto_rx) begin
                    unique case (estado)
                        ESP_CAB:    estado_prox = (dado_rx == CAB_CONFIG) ? ESP_INT_H : ESP_CAB;
                        ESP_INT_H:  estado_prox = ESP_INT_L;
                        ESP_INT_L:  estado_prox = ESP_LIMIAR;
                        ESP_LIMIAR: estado_prox = ESP_CHK;
                        default:    estado_prox = VALIDA;
                    endcase
                end else if (fim_timeout) begin
                    estado_prox = ERRO;
                end
            end
            VALIDA: begin
                if (cancelar)       estado_prox = OCIOSO;
                else if (quadro_ok) estado_prox = ATUALIZA;
                else                estado_prox = ERRO;
            end
            ATUALIZA, ERRO: estado_prox = OCIOSO;
            default:        estado_prox = OCIOSO;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // in the same cycle as the state register and never glitch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado        <= OCIOSO;
            sh_int_h      <= '0;
            sh_int_l      <= '0;
            sh_limiar     <= '0;
            sh_chk        <= '0;
            intervalo     <= INTERVALO_RESET;
            limiar_temp   <= LIMIAR_RESET;
            pronto_config <= 1'b0;
            erro_config   <= 1'b0;
            recebendo     <= 1'b0;
            db_estado     <= ST_OCIOSO;
        end else begin
            estado        <= estado_prox;
            pronto_config <= (estado_prox == ATUALIZA) || (estado_prox == ERRO);
            erro_config   <= (estado_prox == ERRO);
            recebendo     <= em_coleta(estado_prox);
            db_estado     <= estado_prox;

            if (byte_aceito) begin
                case (estado)
                    ESP_INT_H:  sh_int_h  <= dado_rx;
                    ESP_INT_L:  sh_int_l  <= dado_rx;
                    ESP_LIMIAR: sh_limiar <= dado_rx;
                    ESP_CHK:    sh_chk    <= dado_rx;
                    default:    ;
                endcase
            end

            // Commit on entry to ATUALIZA so the new values are already
            // visible while pronto_config is high.
            if (estado_prox == ATUALIZA) begin
                intervalo   <= {sh_int_h, sh_int_l};
                limiar_temp <= sh_limiar;
            end
        end
    end

endmodule

// File: tb/tb_tusca_recepcao_config.sv
module tb_tusca_recepcao_config;

    localparam int          TIMEOUT = 100;
    localparam logic [15:0] INT_RST = 16'h1234;
    localparam logic [7:0]  LIM_RST = 8'h55;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        receber_config = 1'b0;
    logic        cancelar = 1'b0;
    logic [7:0]  dado_rx = 8'h00;
    logic        pronto_rx = 1'b0;
    logic        pronto_config, erro_config, recebendo;
    logic [15:0] intervalo;
    logic [7:0]  limiar_temp;
    logic [3:0]  db_estado;

    typedef struct {
        logic        erro;
        logic [15:0] intervalo;
        logic [7:0]  limiar;
    } esperado_t;

    typedef logic [7:0] bytes_t[$];

    esperado_t sb[$];
    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    tusca_recepcao_config #(
        .TIMEOUT_CICLOS  (TIMEOUT),
        .INTERVALO_RESET (INT_RST),
        .LIMIAR_RESET    (LIM_RST)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .receber_config (receber_config),
        .cancelar       (cancelar),
        .dado_rx        (dado_rx),
        .pronto_rx      (pronto_rx),
        .pronto_config  (pronto_config),
        .erro_config    (erro_config),
        .intervalo      (intervalo),
        .limiar_temp    (limiar_temp),
        .recebendo      (recebendo),
        .db_estado      (db_estado)
    );

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual !== esperado) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", nome, atual, esperado, $time);
        end
    endtask

    // Monitor: every pronto_config pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && pronto_config) begin
            if (sb.size() == 0) begin
                check("pronto_inesperado", {31'd0, pronto_config}, 32'd0);
            end else begin
                esperado_t e;
                e = sb.pop_front();
                check("erro_config", {31'd0, erro_config}, {31'd0, e.erro});
                @(negedge clock);
                check("pronto_largura", {31'd0, pronto_config}, 32'd0);
                check("intervalo", {16'd0, intervalo}, {16'd0, e.intervalo});
                check("limiar_temp", {24'd0, limiar_temp}, {24'd0, e.limiar});
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && erro_config && !pronto_config)
            check("erro_sem_pronto", {31'd0, erro_config}, 32'd0);
    end

    task automatic esperar(input logic erro, input logic [15:0] i, input logic [7:0] l);
        esperado_t e;
        e.erro = erro; e.intervalo = i; e.limiar = l;
        sb.push_back(e);
    endtask

    task automatic iniciar();
        @(negedge clock); receber_config = 1'b1;
        @(negedge clock); receber_config = 1'b0;
    endtask

    task automatic enviar(input logic [7:0] b, input logic canc);
        @(negedge clock); dado_rx = b; pronto_rx = 1'b1; cancelar = canc;
        @(negedge clock); pronto_rx = 1'b0; cancelar = 1'b0;
    endtask

    task automatic enviar_seq(input bytes_t s);
        foreach (s[i]) enviar(s[i], 1'b0);
    endtask

    // Bounded wait for the scoreboard to empty, then two idle cycles so the
    // monitor finishes its follow-up checks.
    task automatic drenar(input int ciclos);
        for (int i = 0; i < ciclos; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        check("scoreboard_vazio", sb.size(), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic checar_reset();
        check("rst_db_estado", {28'd0, db_estado}, 32'd0);
        check("rst_intervalo", {16'd0, intervalo}, {16'd0, INT_RST});
        check("rst_limiar", {24'd0, limiar_temp}, {24'd0, LIM_RST});
        check("rst_pronto", {30'd0, pronto_config, erro_config}, 32'd0);
        check("rst_recebendo", {31'd0, recebendo}, 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bytes_t f;

        repeat (3) @(negedge clock);
        checar_reset();
        reset_n = 1'b1;
        @(negedge clock);
        checar_reset();

        // 1: valid frame, checksum 43^07^D0^1E = 8A
        esperar(1'b0, 16'h07D0, 8'h1E);
        iniciar();
        check("t1_estado_cab", {28'd0, db_estado}, 32'd1);
        check("t1_recebendo", {31'd0, recebendo}, 32'd1);
        f = {8'h43, 8'h07, 8'hD0, 8'h1E, 8'h8A};
        enviar_seq(f);
        check("t1_valida_latencia", {28'd0, db_estado}, 32'd6);
        drenar(10);

        // 2: bad checksum, committed values stay
        esperar(1'b1, 16'h07D0, 8'h1E);
        iniciar();
        f = {8'h43, 8'h07, 8'hD0, 8'h1E, 8'h00};
        enviar_seq(f);
        drenar(10);

        // 3: resync, 55 and 12 discarded; checksum 43^00^0A^19 = 50
        esperar(1'b0, 16'h000A, 8'h19);
        iniciar();
        enviar(8'h55, 1'b0);
        check("t3_descarta", {28'd0, db_estado}, 32'd1);
        f = {8'h12, 8'h43, 8'h00, 8'h0A, 8'h19, 8'h50};
        enviar_seq(f);
        drenar(10);

        // 4: timeout after 43 07; ERRO exactly TIMEOUT cycles after the last byte
        esperar(1'b1, 16'h000A, 8'h19);
        iniciar();
        f = {8'h43, 8'h07};
        enviar_seq(f);
        repeat (TIMEOUT - 1) @(negedge clock);
        check("t4_antes_timeout", {28'd0, db_estado}, 32'd3);
        drenar(5);
        f = {8'h43, 8'h07, 8'hD0, 8'h1E, 8'h8A};
        enviar_seq(f);
        check("t4_ignora_bytes", {28'd0, db_estado}, 32'd0);
        repeat (4) @(negedge clock);
        check("t4_intervalo", {16'd0, intervalo}, 32'h000A);

        // 5: cancel on the 3rd strobe; a start pulse mid-frame is ignored
        iniciar();
        f = {8'h43, 8'h07};
        enviar_seq(f);
        iniciar();
        check("t5_start_ignorado", {28'd0, db_estado}, 32'd3);
        enviar(8'hD0, 1'b1);
        check("t5_cancel_estado", {28'd0, db_estado}, 32'd0);
        check("t5_cancel_recebendo", {31'd0, recebendo}, 32'd0);
        repeat (4) @(negedge clock);
        check("t5_intervalo", {16'd0, intervalo}, 32'h000A);
        check("t5_limiar", {24'd0, limiar_temp}, 32'h19);

        // 6: zero interval with a correct checksum is rejected
        esperar(1'b1, 16'h000A, 8'h19);
        iniciar();
        f = {8'h43, 8'h00, 8'h00, 8'h1E, 8'h5D};
        enviar_seq(f);
        drenar(10);

        // reset in mid-frame restores reset values
        iniciar();
        f = {8'h43, 8'h07};
        enviar_seq(f);
        check("t6_meio_quadro", {28'd0, db_estado}, 32'd3);
        reset_n = 1'b0;
        #1;
        checar_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checar_reset();
        check("sb_final", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
